obi_xbar_rr: RTL and testbench

OBI_XBAR_RR -- requirements
Module: obi_xbar_rr

---
 rtl/obi_xbar_rr_if.sv | 42 ++++
 rtl/obi_xbar_rr.sv | 181 ++++++++++++++++++
 tb/tb_obi_xbar_rr.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_xbar_rr_if.sv
// obi_xbar_rr_if: subordinate-side and manager-side OBI bundles of the crossbar.
// slave = crossbar view, master = environment view.
interface obi_xbar_rr_if #(
    parameter int NumSbr    = 2,
    parameter int NumMgr    = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic [NumSbr-1:0]                  sbr_req_i;
    logic [NumSbr-1:0]                  sbr_gnt_o;
    logic [NumSbr-1:0][AddrWidth-1:0]   sbr_addr_i;
    logic [NumSbr-1:0]                  sbr_we_i;
    logic [NumSbr-1:0][DataWidth/8-1:0] sbr_be_i;
    logic [NumSbr-1:0][DataWidth-1:0]   sbr_wdata_i;
    logic [NumSbr-1:0]                  sbr_rvalid_o;
    logic [NumSbr-1:0][DataWidth-1:0]   sbr_rdata_o;
    logic [NumSbr-1:0]                  sbr_err_o;

    logic [NumMgr-1:0]                  mgr_req_o;
    logic [NumMgr-1:0]                  mgr_gnt_i;
    logic [NumMgr-1:0][AddrWidth-1:0]   mgr_addr_o;
    logic [NumMgr-1:0]                  mgr_we_o;
    logic [NumMgr-1:0][DataWidth/8-1:0] mgr_be_o;
    logic [NumMgr-1:0][DataWidth-1:0]   mgr_wdata_o;
    logic [NumMgr-1:0]                  mgr_rvalid_i;
    logic [NumMgr-1:0][DataWidth-1:0]   mgr_rdata_i;
    logic [NumMgr-1:0]                  mgr_err_i;

    modport slave (
        input  sbr_req_i, sbr_addr_i, sbr_we_i, sbr_be_i, sbr_wdata_i,
        output sbr_gnt_o, sbr_rvalid_o, sbr_rdata_o, sbr_err_o,
        output mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o,
        input  mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i
    );

    modport master (
        output sbr_req_i, sbr_addr_i, sbr_we_i, sbr_be_i, sbr_wdata_i,
        input  sbr_gnt_o, sbr_rvalid_o, sbr_rdata_o, sbr_err_o,
        input  mgr_req_o, mgr_addr_o, mgr_we_o, mgr_be_o, mgr_wdata_o,
        output mgr_gnt_i, mgr_rvalid_i, mgr_rdata_i, mgr_err_i
    );
endinterface

// File: rtl/obi_xbar_rr.sv
// obi_xbar_rr: OBI crossbar, round-robin per manager, in-order ID FIFOs.
// Define OBI_XBAR_RR_PERF_EN to build the per-manager conflict counters.
module obi_xbar_rr #(
    parameter int NumSbr      = 2,
    parameter int NumMgr      = 2,
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int NumRules    = 2,
    parameter int NumMaxTrans = 4,
    localparam int IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    obi_xbar_rr_if.slave                       bus,
    input  logic [NumRules-1:0][AddrWidth-1:0] rule_start_i,
    input  logic [NumRules-1:0][AddrWidth-1:0] rule_end_i,
    input  logic [NumRules-1:0][IdxW-1:0]      rule_idx_i,
    output logic                               fault_o,
    output logic [NumMgr-1:0][15:0]            conflict_cnt_o
);
    localparam int TW = $clog2(NumMgr + 1);
    localparam int SW = (NumSbr > 1) ? $clog2(NumSbr) : 1;
    localparam int PW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
    localparam int CW = $clog2(NumMaxTrans + 1);
    localparam logic [TW-1:0] ErrTgt = TW'(NumMgr);

    logic [NumSbr-1:0][TW-1:0] tgt, cur_tgt_q;
    logic [NumSbr-1:0][CW-1:0] out_cnt_q;
    logic [NumSbr-1:0]         elig, err_gnt, err_pend_q;
    logic [NumMgr-1:0][SW-1:0] win, rr_ptr_q;
    logic [NumMgr-1:0]         found, full, hs, pop;
    logic [NumMgr-1:0][NumMaxTrans-1:0][SW-1:0] fifo_q;
    logic [NumMgr-1:0][PW-1:0] wptr_q, rptr_q;
    logic [NumMgr-1:0][CW-1:0] occ_q;
    logic [SW-1:0]             sel, head;
    int                        idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // Decode targets (lowest rule wins) and block target switches while busy.
    always_comb begin
        for (int s = 0; s < NumSbr; s++) begin
            tgt[s] = ErrTgt;
            for (int r = NumRules - 1; r >= 0; r--) begin
                if (bus.sbr_addr_i[s] >= rule_start_i[r] &&
                    bus.sbr_addr_i[s] <  rule_end_i[r])
                    tgt[s] = TW'(rule_idx_i[r]);
            end
            elig[s] = bus.sbr_req_i[s] &&
                      (out_cnt_q[s] == '0 || cur_tgt_q[s] == tgt[s]);
        end
    end

    // Round-robin pick per manager and zero-latency A-channel forwarding.
    always_comb begin
        idx = 0;
        sel = '0;
        bus.mgr_req_o   = '0;
        bus.mgr_addr_o  = '0;
        bus.mgr_we_o    = '0;
        bus.mgr_be_o    = '0;
        bus.mgr_wdata_o = '0;
        for (int m = 0; m < NumMgr; m++) begin
            found[m] = 1'b0;
            win[m]   = '0;
            for (int k = 0; k < NumSbr; k++) begin
                idx = int'(rr_ptr_q[m]) + k;
                if (idx >= NumSbr) idx = idx - NumSbr;
                sel = SW'(idx);
                if (!found[m] && elig[sel] && tgt[sel] == TW'(m)) begin
                    found[m] = 1'b1;
                    win[m]   = sel;
                end
            end
            full[m] = occ_q[m] == CW'(NumMaxTrans);
            bus.mgr_req_o[m]   = found[m] && !full[m];
            bus.mgr_addr_o[m]  = bus.sbr_addr_i[win[m]];
            bus.mgr_we_o[m]    = bus.sbr_we_i[win[m]];
            bus.mgr_be_o[m]    = bus.sbr_be_i[win[m]];
            bus.mgr_wdata_o[m] = bus.sbr_wdata_i[win[m]];
            hs[m]  = bus.mgr_req_o[m] && bus.mgr_gnt_i[m];
            pop[m] = bus.mgr_rvalid_i[m] && occ_q[m] != '0;
        end
    end

    // Grants back to subordinates; responses routed by FIFO head or error slot.
    always_comb begin
        bus.sbr_gnt_o    = '0;
        bus.sbr_rvalid_o = '0;
        bus.sbr_rdata_o  = '0;
        bus.sbr_err_o    = '0;
        err_gnt          = '0;
        head             = '0;
        for (int s = 0; s < NumSbr; s++) begin
            if (elig[s] && tgt[s] == ErrTgt) begin
                err_gnt[s]       = 1'b1;
                bus.sbr_gnt_o[s] = 1'b1;
            end
            if (err_pend_q[s]) begin
                bus.sbr_rvalid_o[s] = 1'b1;
                bus.sbr_err_o[s]    = 1'b1;
                bus.sbr_rdata_o[s]  = DataWidth'(32'hBADCAB1E);
            end
        end
        for (int m = 0; m < NumMgr; m++) begin
            if (hs[m]) bus.sbr_gnt_o[win[m]] = 1'b1;
            if (pop[m]) begin
                head = fifo_q[m][rptr_q[m]];
                bus.sbr_rvalid_o[head] = 1'b1;
                bus.sbr_rdata_o[head]  = bus.mgr_rdata_i[m];
                bus.sbr_err_o[head]    = bus.mgr_err_i[m];
            end
        end
    end

    // ID FIFOs, RR pointers, per-subordinate bookkeeping and sticky fault.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fifo_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            rr_ptr_q   <= '0;
            out_cnt_q  <= '0;
            cur_tgt_q  <= '0;
            err_pend_q <= '0;
            fault_o    <= 1'b0;
        end else begin
            for (int m = 0; m < NumMgr; m++) begin
                if (hs[m]) begin
                    fifo_q[m][wptr_q[m]] <= win[m];
                    wptr_q[m]   <= ptr_inc(wptr_q[m]);
                    rr_ptr_q[m] <= (win[m] == SW'(NumSbr - 1)) ? '0 : win[m] + 1'b1;
                end
                if (pop[m]) rptr_q[m] <= ptr_inc(rptr_q[m]);
                occ_q[m] <= occ_q[m] + CW'(hs[m]) - CW'(pop[m]);
                if (bus.mgr_rvalid_i[m] && occ_q[m] == '0) fault_o <= 1'b1;
            end
            for (int s = 0; s < NumSbr; s++) begin
                err_pend_q[s] <= err_gnt[s];
                if (bus.sbr_gnt_o[s]) cur_tgt_q[s] <= tgt[s];
                out_cnt_q[s] <= out_cnt_q[s] + CW'(bus.sbr_gnt_o[s])
                                - CW'(bus.sbr_rvalid_o[s]);
            end
        end
    end

`ifdef OBI_XBAR_RR_PERF_EN
    logic [NumMgr-1:0]       conflict;
    logic [NumMgr-1:0][15:0] conf_q;
    int                      nreq;

    // A conflict is two or more raw requests aimed at the same manager.
    always_comb begin
        nreq = 0;
        for (int m = 0; m < NumMgr; m++) begin
            nreq = 0;
            for (int s = 0; s < NumSbr; s++)
                if (bus.sbr_req_i[s] && tgt[s] == TW'(m)) nreq = nreq + 1;
            conflict[m] = nreq >= 2;
        end
    end

    // Saturating conflict counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            conf_q <= '0;
        end else begin
            for (int m = 0; m < NumMgr; m++)
                if (conflict[m] && conf_q[m] != 16'hFFFF)
                    conf_q[m] <= conf_q[m] + 16'd1;
        end
    end

    assign conflict_cnt_o = conf_q;
`else
    assign conflict_cnt_o = '0;
`endif
endmodule

// File: tb/tb_obi_xbar_rr.sv
// tb_obi_xbar_rr: directed stimulus, queue-based reference model checked
// every cycle on the falling edge, plus literal expectations per scenario.
module tb_obi_xbar_rr;
    localparam int NS = 2;
    localparam int NM = 2;
    localparam int NR = 2;
    localparam int MT = 4;

    logic clk;
    logic rst_n;
    logic [NR-1:0][31:0] rs, re;
    logic [NR-1:0][0:0]  ri;
    logic                fault;
    logic [NM-1:0][15:0] conf_cnt;

    int checks = 0;
    int errors = 0;

    obi_xbar_rr_if #(.NumSbr(NS), .NumMgr(NM), .AddrWidth(32), .DataWidth(32)) bus ();

    obi_xbar_rr #(
        .NumSbr(NS), .NumMgr(NM), .AddrWidth(32), .DataWidth(32),
        .NumRules(NR), .NumMaxTrans(MT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus),
        .rule_start_i   (rs),
        .rule_end_i     (re),
        .rule_idx_i     (ri),
        .fault_o        (fault),
        .conflict_cnt_o (conf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int rr_m[NM];
    int idq[NM][$];
    int outst[NS];
    int dest[NS];
    bit errp[NS];
    bit flt;
    int conf[NM];

    function automatic int decode(input logic [31:0] a);
        for (int r = 0; r < NR; r++)
            if (a >= rs[r] && a < re[r]) return int'(ri[r]);
        return NM;
    endfunction

    always @(negedge clk) begin : model
        int tg[NS];
        bit ok[NS];
        int w[NM];
        logic [NS-1:0] eg, erv, ee;
        logic [NM-1:0] er;
        logic [31:0] erd[NS];
        int h, n, i;
        if (!rst_n) begin
            for (int m = 0; m < NM; m++) begin
                rr_m[m] = 0;
                idq[m].delete();
                conf[m] = 0;
            end
            for (int s = 0; s < NS; s++) begin
                outst[s] = 0;
                dest[s]  = 0;
                errp[s]  = 0;
            end
            flt = 0;
        end else begin
            eg = '0; erv = '0; ee = '0; er = '0;
            for (int s = 0; s < NS; s++) begin
                tg[s]  = decode(bus.sbr_addr_i[s]);
                ok[s]  = bus.sbr_req_i[s] && (outst[s] == 0 || dest[s] == tg[s]);
                erd[s] = 32'h0;
                if (ok[s] && tg[s] == NM) eg[s] = 1'b1;
            end
            for (int m = 0; m < NM; m++) begin
                w[m] = -1;
                for (int k = 0; k < NS; k++) begin
                    i = (rr_m[m] + k) % NS;
                    if (w[m] < 0 && ok[i] && tg[i] == m) w[m] = i;
                end
                er[m] = (w[m] >= 0) && (idq[m].size() < MT);
                if (er[m] && bus.mgr_gnt_i[m]) eg[w[m]] = 1'b1;
            end
            for (int s = 0; s < NS; s++)
                if (errp[s]) begin
                    erv[s] = 1'b1; ee[s] = 1'b1; erd[s] = 32'hBADCAB1E;
                end
            for (int m = 0; m < NM; m++)
                if (bus.mgr_rvalid_i[m] && idq[m].size() > 0) begin
                    h = idq[m][0];
                    erv[h] = 1'b1;
                    ee[h]  = bus.mgr_err_i[m];
                    erd[h] = bus.mgr_rdata_i[m];
                end
            chk("m_sbr_gnt", 64'(bus.sbr_gnt_o), 64'(eg));
            chk("m_sbr_rvalid", 64'(bus.sbr_rvalid_o), 64'(erv));
            chk("m_sbr_err", 64'(bus.sbr_err_o & erv), 64'(ee));
            for (int s = 0; s < NS; s++)
                chk("m_sbr_rdata", 64'(bus.sbr_rdata_o[s]), 64'(erd[s]));
            chk("m_mgr_req", 64'(bus.mgr_req_o), 64'(er));
            for (int m = 0; m < NM; m++) begin
                if (er[m]) begin
                    chk("m_mgr_addr", 64'(bus.mgr_addr_o[m]), 64'(bus.sbr_addr_i[w[m]]));
                    chk("m_mgr_we", 64'(bus.mgr_we_o[m]), 64'(bus.sbr_we_i[w[m]]));
                    chk("m_mgr_be", 64'(bus.mgr_be_o[m]), 64'(bus.sbr_be_i[w[m]]));
                    chk("m_mgr_wdata", 64'(bus.mgr_wdata_o[m]), 64'(bus.sbr_wdata_i[w[m]]));
                end
                chk("m_conflict", 64'(conf_cnt[m]), 64'(conf[m]));
            end
            chk("m_fault", 64'(fault), 64'(flt));
            // advance model state to the next cycle
            for (int m = 0; m < NM; m++) begin
`ifdef OBI_XBAR_RR_PERF_EN
                n = 0;
                for (int s = 0; s < NS; s++)
                    if (bus.sbr_req_i[s] && tg[s] == m) n++;
                if (n >= 2 && conf[m] < 65535) conf[m]++;
`endif
                if (bus.mgr_rvalid_i[m]) begin
                    if (idq[m].size() == 0) flt = 1;
                    else void'(idq[m].pop_front());
                end
                if (er[m] && bus.mgr_gnt_i[m]) begin
                    idq[m].push_back(w[m]);
                    rr_m[m] = (w[m] + 1) % NS;
                end
            end
            for (int s = 0; s < NS; s++) begin
                outst[s] = outst[s] + int'(eg[s]) - int'(erv[s]);
                if (eg[s]) dest[s] = tg[s];
                errp[s] = eg[s] && tg[s] == NM;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.sbr_req_i    = '0;
        bus.sbr_addr_i   = '0;
        bus.sbr_we_i     = '0;
        bus.sbr_be_i     = '0;
        bus.sbr_wdata_i  = '0;
        bus.mgr_gnt_i    = '1;
        bus.mgr_rvalid_i = '0;
        bus.mgr_rdata_i  = '0;
        bus.mgr_err_i    = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        rs[0] = 32'h1000; re[0] = 32'h2000; ri[0] = 1'b1;
        rs[1] = 32'h0000; re[1] = 32'h3000; ri[1] = 1'b0;
        idle();
        repeat (2) cyc();
        rst_n = 1'b1;
        #2;
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_mgr_req", 64'(bus.mgr_req_o), 64'd0);
        chk("rst_rvalid", 64'(bus.sbr_rvalid_o), 64'd0);
        chk("rst_conflict", 64'(conf_cnt), 64'd0);

        // single read through rule0 (overlaps rule1) to mgr1
        cyc();
        bus.sbr_req_i[0] = 1'b1; bus.sbr_addr_i[0] = 32'h1800;
        #2;
        chk("a_gnt", 64'(bus.sbr_gnt_o), 64'h1);
        chk("a_mgr_req", 64'(bus.mgr_req_o), 64'h2);
        chk("a_addr", 64'(bus.mgr_addr_o[1]), 64'h1800);
        cyc();
        idle();
        bus.mgr_rvalid_i[1] = 1'b1; bus.mgr_rdata_i[1] = 32'h1234;
        #2;
        chk("a_rvalid", 64'(bus.sbr_rvalid_o), 64'h1);
        chk("a_rdata", 64'(bus.sbr_rdata_o[0]), 64'h1234);
        chk("a_err", 64'(bus.sbr_err_o[0]), 64'h0);
        cyc();
        idle();

        // two subordinates contend for mgr0
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.sbr_req_i = 2'b11;
            bus.sbr_addr_i[0] = 32'h0100; bus.sbr_addr_i[1] = 32'h0104;
            bus.mgr_rvalid_i[0] = (k > 0);
            bus.mgr_rdata_i[0]  = 32'(k);
            #2;
            chk("b_gnt", 64'(bus.sbr_gnt_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k == 1) chk("b_rvalid", 64'(bus.sbr_rvalid_o), 64'h1);
        end
        cyc();
        idle();
        bus.mgr_rvalid_i[0] = 1'b1; bus.mgr_rdata_i[0] = 32'h55;
        #2;
        chk("b_last_rvalid", 64'(bus.sbr_rvalid_o), 64'h2);
`ifdef OBI_XBAR_RR_PERF_EN
        chk("b_conflict", 64'(conf_cnt[0]), 64'd4);
`else
        chk("b_conflict", 64'(conf_cnt[0]), 64'd0);
`endif
        cyc();
        idle();

        // fill mgr0 ID FIFO
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus.sbr_req_i[0] = 1'b1; bus.sbr_addr_i[0] = 32'h0200;
            #2;
            chk("c_gnt", 64'(bus.sbr_gnt_o), 64'h1);
        end
        cyc();
        #2;
        chk("c_full_req", 64'(bus.mgr_req_o[0]), 64'h0);
        chk("c_full_gnt", 64'(bus.sbr_gnt_o), 64'h0);
        cyc();
        bus.mgr_rvalid_i[0] = 1'b1; bus.mgr_rdata_i[0] = 32'h10;
        #2;
        chk("c_pop_req", 64'(bus.mgr_req_o[0]), 64'h0);
        chk("c_pop_rdata", 64'(bus.sbr_rdata_o[0]), 64'h10);
        cyc();
        bus.mgr_rvalid_i[0] = 1'b0;
        #2;
        chk("c_resume_req", 64'(bus.mgr_req_o[0]), 64'h1);
        chk("c_resume_gnt", 64'(bus.sbr_gnt_o), 64'h1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            idle();
            bus.mgr_rvalid_i[0] = 1'b1; bus.mgr_rdata_i[0] = 32'h20 + 32'(k);
        end
        cyc();
        idle();

        // target switch waits for outstanding responses
        cyc();
        bus.sbr_req_i[0] = 1'b1; bus.sbr_addr_i[0] = 32'h0300;
        cyc();
        cyc();
        bus.sbr_addr_i[0] = 32'h1800;
        #2;
        chk("d_block_gnt", 64'(bus.sbr_gnt_o), 64'h0);
        chk("d_block_req", 64'(bus.mgr_req_o), 64'h0);
        cyc();
        bus.mgr_rvalid_i[0] = 1'b1;
        #2;
        chk("d_block_gnt1", 64'(bus.sbr_gnt_o), 64'h0);
        cyc();
        #2;
        chk("d_block_gnt2", 64'(bus.sbr_gnt_o), 64'h0);
        cyc();
        bus.mgr_rvalid_i[0] = 1'b0;
        #2;
        chk("d_switch_gnt", 64'(bus.sbr_gnt_o), 64'h1);
        chk("d_switch_req", 64'(bus.mgr_req_o), 64'h2);
        cyc();
        idle();
        bus.mgr_rvalid_i[1] = 1'b1; bus.mgr_rdata_i[1] = 32'h77;
        cyc();
        idle();

        // unmapped address answered by the internal error target
        cyc();
        bus.sbr_req_i[1] = 1'b1; bus.sbr_addr_i[1] = 32'h8000;
        #2;
        chk("e_gnt", 64'(bus.sbr_gnt_o), 64'h2);
        chk("e_mgr_req", 64'(bus.mgr_req_o), 64'h0);
        cyc();
        idle();
        #2;
        chk("e_rvalid", 64'(bus.sbr_rvalid_o), 64'h2);
        chk("e_err", 64'(bus.sbr_err_o), 64'h2);
        chk("e_rdata", 64'(bus.sbr_rdata_o[1]), 64'hBADCAB1E);
        cyc();
        idle();

        // concurrent read and write to different managers
        cyc();
        bus.sbr_req_i = 2'b11;
        bus.sbr_addr_i[0] = 32'h0100;
        bus.sbr_addr_i[1] = 32'h1004; bus.sbr_we_i[1] = 1'b1;
        bus.sbr_be_i[1] = 4'b0011; bus.sbr_wdata_i[1] = 32'hCAFEF00D;
        #2;
        chk("h_gnt", 64'(bus.sbr_gnt_o), 64'h3);
        chk("h_mgr_req", 64'(bus.mgr_req_o), 64'h3);
        chk("h_we", 64'(bus.mgr_we_o[1]), 64'h1);
        chk("h_be", 64'(bus.mgr_be_o[1]), 64'h3);
        chk("h_wdata", 64'(bus.mgr_wdata_o[1]), 64'hCAFEF00D);
        cyc();
        idle();
        bus.mgr_rvalid_i = 2'b11;
        bus.mgr_rdata_i[0] = 32'hA0; bus.mgr_rdata_i[1] = 32'hB1;
        bus.mgr_err_i[1] = 1'b1;
        #2;
        chk("h_rvalid", 64'(bus.sbr_rvalid_o), 64'h3);
        chk("h_rdata0", 64'(bus.sbr_rdata_o[0]), 64'hA0);
        chk("h_rdata1", 64'(bus.sbr_rdata_o[1]), 64'hB1);
        chk("h_err", 64'(bus.sbr_err_o), 64'h2);
        cyc();
        idle();

        // stray response raises a sticky fault
        cyc();
        bus.mgr_rvalid_i[1] = 1'b1; bus.mgr_rdata_i[1] = 32'h99;
        #2;
        chk("f_dropped", 64'(bus.sbr_rvalid_o), 64'h0);
        cyc();
        idle();
        #2;
        chk("f_fault", 64'(fault), 64'h1);
        repeat (3) cyc();
        chk("f_sticky", 64'(fault), 64'h1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #2;
        chk("f_cleared", 64'(fault), 64'h0);

        // reset with a transaction in flight
        cyc();
        bus.sbr_req_i[0] = 1'b1; bus.sbr_addr_i[0] = 32'h1800;
        cyc();
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.mgr_rvalid_i[1] = 1'b1; bus.mgr_rdata_i[1] = 32'h5;
        #2;
        chk("g_dropped", 64'(bus.sbr_rvalid_o), 64'h0);
        cyc();
        idle();
        bus.sbr_req_i[0] = 1'b1; bus.sbr_addr_i[0] = 32'h0100;
        #2;
        chk("g_fault", 64'(fault), 64'h1);
        chk("g_fresh_gnt", 64'(bus.sbr_gnt_o), 64'h1);
        cyc();
        idle();
        bus.mgr_rvalid_i[0] = 1'b1;
        cyc();
        idle();
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
